// File: rtl/param_port_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_port_ram_pkg : shared constants and clear-FSM state encoding  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package param_port_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/param_port_ram_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_port_ram_if : request/response and clear-control bundle       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface param_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 8
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  write_enable;
  logic [NUM_LANES-1:0]  lane_enable;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rsp_valid;
  logic                  clear_start;
  logic                  clear_busy;

  modport master (
    output req_valid, write_enable, lane_enable, ram_address, data_in, clear_start,
    input  req_ready, data_out, rsp_valid, clear_busy
  );

  modport slave (
    input  req_valid, write_enable, lane_enable, ram_address, data_in, clear_start,
    output req_ready, data_out, rsp_valid, clear_busy
  );
endinterface
`default_nettype wire

// File: rtl/param_port_ram_clear_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_clear_seq : walks every address writing zero after reset/on demand |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ram_clear_seq
  import param_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  req_ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = clr_addr;
    case (state)
      CLEAR: begin
        // All-ones is the last word; stop there rather than wrapping.
        if (clr_addr == '1) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end else begin
          addr_nxt = clr_addr + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (clear_start) begin
          state_nxt = CLEAR;
          addr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        addr_nxt  = '0;
      end
    endcase
  end

  // Decoded straight from the state flop, so no path from req_valid.
  assign clear_busy = (state == CLEAR);
  assign req_ready  = (state == IDLE);
  assign clr_we     = (state == CLEAR);

endmodule
`default_nettype wire

// File: rtl/param_port_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_port_ram : single-port RAM with lane writes, RDW modes, clear |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module param_port_ram
  import param_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic           clk,
  input logic           rst,
  param_port_ram_if.slave bus
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clear_busy;
  logic                  req_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk         (clk),
    .rst         (rst),
    .clear_start (bus.clear_start),
    .clear_busy  (clear_busy),
    .req_ready   (req_ready),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr)
  );

  assign bus.clear_busy = clear_busy;
  assign bus.req_ready  = req_ready;
  assign accept         = bus.req_valid && req_ready;
  assign rd_word        = mem[bus.ram_address];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lane_enable[i]) begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = bus.data_in[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // req_ready is low while clearing, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (accept && bus.write_enable) begin
      mem[bus.ram_address] <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept && !bus.write_enable;
      if (accept) begin
        if (!bus.write_enable) begin
          s1_data <= rd_word;
        end else if (RDW_MODE == RDW_READ_FIRST) begin
          s1_data <= rd_word;
        end else if (RDW_MODE == RDW_WRITE_FIRST) begin
          s1_data <= merged;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      // s1_data already holds between updates, so a plain delay preserves that.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign bus.data_out  = s2_data;
      assign bus.rsp_valid = s2_valid;
    end else begin : g_no_out_reg
      assign bus.data_out  = s1_data;
      assign bus.rsp_valid = s1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/param_port_ram.md
# param_port_ram

Parametrised single-port synchronous RAM: the next generation of the 64×8 single-port RAM. It adds configurable width and depth, per-lane byte write enables, a selectable read-during-write mode, an optional output register stage, a valid/ready request handshake and a hardware clear sequencer that zeroes the array after reset or on demand. It is the default on-chip scratch store for datapath blocks that need one access per cycle.

## Interface
- DATA_WIDTH, default 8: word width in bits; must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, default 6: address width; DEPTH = 2**ADDR_WIDTH words.
- LANE_WIDTH, default 8: bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- RDW_MODE, default 0: data_out on a write. 0 = READ_FIRST (old word), 1 = WRITE_FIRST (merged new word), 2 = NO_CHANGE (hold).
- OUT_REG, default 0: 1 adds one output register stage.
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  RAM can accept a request (low while clearing).
- write_enable  in  1  1 = write, 0 = read.
- lane_enable  in  NUM_LANES  per-lane write mask; ignored on reads.
- ram_address  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read/RDW data; holds between updates.
- rsp_valid  out  1  one-cycle pulse marking read data on data_out.
- clear_start  in  1  pulse to request a full-array clear.
- clear_busy  out  1  high during a clear sequence.

## Operation
- Accept a request when req_valid && req_ready. The block never stalls otherwise; sustained throughput is one access per cycle.
- Write: memory[addr] lane i takes data_in lane i where lane_enable[i]=1. Other lanes are unchanged. A write with lane_enable all zero changes nothing but still applies RDW_MODE.
- Read: data_out returns memory[addr] and rsp_valid pulses. Writes never raise rsp_valid.
- RDW on a write op:
  - READ_FIRST: data_out updates to the pre-write word.
  - WRITE_FIRST: data_out updates to the post-merge word.
  - NO_CHANGE: data_out holds.
- Clear sequencer FSM:
  - CLEAR: writes zero to address clr_addr (ADDR_WIDTH counter) each cycle, from 0 up to DEPTH-1. clear_busy=1, req_ready=0. After writing DEPTH-1, go to IDLE.
  - IDLE: clear_busy=0, req_ready=1. clear_start=1 moves to CLEAR with clr_addr=0.
- Reset values: state=CLEAR, clr_addr=0, req_ready=0, clear_busy=1, rsp_valid=0, data_out=0. The output pipeline register is also 0 and invalid. Array contents are not reset directly; the post-reset CLEAR zeroes them.
- Boundary cases:
  - clear_start in the same cycle as an accepted request: the request completes normally, and CLEAR starts the next cycle.
  - clear_start during CLEAR: ignored (no restart).
  - rst asserted mid-CLEAR: the sequence restarts from address 0 after reset is released.
  - Responses already in flight (OUT_REG=1) still complete when CLEAR begins.
  - Counter wrap: clr_addr reaching DEPTH-1 ends the sequence; it never wraps into a second pass.
  - Back-to-back write then read of the same address: the read returns the new data.

## Timing
- Request accepted at edge N:
  - OUT_REG=0: data_out/rsp_valid valid after edge N+1.
  - OUT_REG=1: valid after edge N+2.
- Fully pipelined: requests on consecutive cycles give responses on consecutive cycles, in order.
- A clear lasts exactly DEPTH cycles.
  - After reset deassertion: req_ready rises after DEPTH rising edges.
  - After clear_start is sampled at edge M: req_ready is low from M+1 and high again from M+1+DEPTH.
- req_ready is a registered output, with no combinational path from req_valid.

## Structure
- Package param_port_ram_pkg holds:
  - the RDW_MODE constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2;
  - the clear FSM state encoding (CLEAR, IDLE).
- Sub-module ram_clear_seq contains the FSM, clr_addr counter, clear_busy/req_ready and the zero-write port signals. The top level muxes its write port with the user request.
- Storage array, lane merge, RDW mux and optional output stage live in param_port_ram.

## Test plan
- Reset, then idle: clear_busy=1 for 64 cycles (default params), then req_ready=1. Read all 64 addresses → every data_out=0x00, rsp_valid once per read.
- Write 0xA5 to addr 3, then read addr 3 next cycle → data_out=0xA5 one cycle after the read is accepted (two cycles with OUT_REG=1).
- DATA_WIDTH=32: write 0x11223344, then write 0xAABBCCDD with lane_enable=4'b0101, then read → 0x11BB33DD.
- Each RDW_MODE: addr 5 holds 0x12, write 0x34 → data_out is 0x12 (READ_FIRST), 0x34 (WRITE_FIRST) or unchanged (NO_CHANGE), with rsp_valid=0 in all three modes.
- Write 0xFF to addr 63, pulse clear_start together with a read of addr 63 → read returns 0xFF, req_ready is low for exactly 64 cycles, and a subsequent read of addr 63 returns 0x00.
- Assert rst at clr_addr=30 during a clear → outputs take their reset values immediately, and the clear restarts, lasting 64 cycles after release.
